// File: rtl/fantasticfft_sample_collector.sv
// Groups a serial Q8.8 sample stream into 8-sample frames using two ping-pong banks.
// Optional macro FANTASTICFFT_COLLECT_BITREV_EN stores samples in bit-reversed slot order.
module fantasticfft_sample_collector #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FRAME_N = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      flush,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [FRAME_N*DATA_W-1:0] frame_x,
  output logic [CNT_W-1:0]          frame_count
);

  if (FRAME_N != 8) begin : g_bad_frame_n
    $error("fantasticfft_sample_collector supports FRAME_N == 8 only");
  end

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_state_e;

  logic [DATA_W-1:0]         bank_q [2][FRAME_N];
  logic [DATA_W-1:0]         bank_d [2][FRAME_N];
  bank_state_e               state_q [2];
  bank_state_e               state_d [2];
  logic                      wb_q, wb_d, rb_q, rb_d;
  logic [2:0]                wr_idx_q, wr_idx_d;
  logic                      in_ready_q, in_ready_d;
  logic                      frame_valid_q, frame_valid_d;
  logic [FRAME_N*DATA_W-1:0] frame_x_q, frame_x_d;
  logic [CNT_W-1:0]          frame_count_q, frame_count_d;

  logic        accept, do_flush, consume, complete;
  int unsigned pad_from;

  function automatic logic [2:0] slot_map(input logic [2:0] idx);
`ifdef FANTASTICFFT_COLLECT_BITREV_EN
    return {idx[0], idx[1], idx[2]};
`else
    return idx;
`endif
  endfunction

  always_comb begin
    bank_d        = bank_q;
    state_d       = state_q;
    wb_d          = wb_q;
    rb_d          = rb_q;
    wr_idx_d      = wr_idx_q;
    frame_valid_d = frame_valid_q;
    frame_x_d     = frame_x_q;
    frame_count_d = frame_count_q;

    accept   = in_valid && in_ready_q;
    do_flush = flush && in_ready_q && ((wr_idx_q != 3'd0) || accept);
    consume  = frame_valid_q && frame_ready;
    complete = (accept && (wr_idx_q == 3'd7)) || do_flush;
    pad_from = int'(wr_idx_q) + (accept ? 1 : 0);

    // Write side: store, zero-pad on flush, close the bank when complete.
    if (accept) begin
      bank_d[wb_q][slot_map(wr_idx_q)] = in_data;
      state_d[wb_q]                    = StFilling;
      wr_idx_d                         = wr_idx_q + 3'd1;
    end
    if (do_flush) begin
      for (int k = 0; k < 8; k++) begin
        if (k >= pad_from) bank_d[wb_q][slot_map(3'(k))] = '0;
      end
    end
    if (complete) begin
      state_d[wb_q] = StFull;
      wb_d          = ~wb_q;
      wr_idx_d      = 3'd0;
    end

    // Read side: decisions use pre-edge bank state, so a bank closed this edge shows next cycle.
    if (consume) begin
      state_d[rb_q] = StEmpty;
      rb_d          = ~rb_q;
      frame_count_d = frame_count_q + CNT_W'(1);
      frame_valid_d = (state_q[~rb_q] == StFull);
      if (state_q[~rb_q] == StFull) begin
        for (int k = 0; k < 8; k++) frame_x_d[k*DATA_W +: DATA_W] = bank_q[~rb_q][k];
      end
    end else if (!frame_valid_q && (state_q[rb_q] == StFull)) begin
      frame_valid_d = 1'b1;
      for (int k = 0; k < 8; k++) frame_x_d[k*DATA_W +: DATA_W] = bank_q[rb_q][k];
    end

    in_ready_d = (state_d[wb_d] != StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= StEmpty;
        for (int k = 0; k < FRAME_N; k++) bank_q[b][k] <= '0;
      end
      wb_q          <= 1'b0;
      rb_q          <= 1'b0;
      wr_idx_q      <= 3'd0;
      in_ready_q    <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_x_q     <= '0;
      frame_count_q <= '0;
    end else begin
      bank_q        <= bank_d;
      state_q       <= state_d;
      wb_q          <= wb_d;
      rb_q          <= rb_d;
      wr_idx_q      <= wr_idx_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
      frame_x_q     <= frame_x_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign frame_valid = frame_valid_q;
  assign frame_x     = frame_x_q;
  assign frame_count = frame_count_q;

endmodule
